// File: rtl/aes_gcm_stream_src.sv
// Transmit stream source for the AES-GCM core: packs 32-bit host words into
// 128-bit AAD and payload beats carrying keep masks and last flags.
module aes_gcm_stream_src (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [63:0]   len_aad_bits,
    input  logic [63:0]   len_pld_bits,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [31:0]   wr_data,
    output logic          aad_valid,
    input  logic          aad_ready,
    output logic [127:0]  aad_data,
    output logic [15:0]   aad_keep,
    output logic          aad_last,
    output logic          din_valid,
    input  logic          din_ready,
    output logic [127:0]  din_data,
    output logic [15:0]   din_keep,
    output logic          din_last,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_AAD_FILL, S_AAD_SEND, S_PLD_FILL, S_PLD_SEND, S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic           start_q;
    logic [60:0]    rem_q, rem_d;
    logic [60:0]    pld_bytes_q, pld_bytes_d;
    logic [1:0]     lane_q, lane_d;
    logic [127:0]   beat_q, beat_d;
    logic           done_q, done_d;
    logic           cfg_err_q, cfg_err_d;

    logic           start_pulse;
    logic           len_ok;
    logic [60:0]    aad_bytes, pld_bytes;
    logic [4:0]     beat_bytes;
    logic [4:0]     beat_bytes_p3;
    logic [2:0]     beat_words;
    logic [15:0]    beat_keep;
    logic           beat_last;
    logic [60:0]    rem_after;
    logic [31:0]    wr_masked;
    logic           last_word;

    assign start_pulse   = start && !start_q;
    assign len_ok        = (len_aad_bits[2:0] == 3'd0) && (len_pld_bits[2:0] == 3'd0);
    assign aad_bytes     = len_aad_bits[63:3];
    assign pld_bytes     = len_pld_bits[63:3];
    assign beat_bytes    = (rem_q >= 61'd16) ? 5'd16 : rem_q[4:0];
    assign beat_bytes_p3 = beat_bytes + 5'd3;
    assign beat_words    = beat_bytes_p3[4:2];
    assign beat_keep     = 16'((17'd1 << beat_bytes) - 17'd1);
    assign beat_last     = (rem_q == 61'(beat_bytes));
    assign rem_after     = rem_q - 61'(beat_bytes);
    assign last_word     = (({1'b0, lane_q} + 3'd1) == beat_words);

    // Bytes past the end of the section are dropped so the beat tail stays zero.
    always_comb begin
        wr_masked = 32'd0;
        for (int k = 0; k < 4; k++) begin
            wr_masked[8*k +: 8] = ({1'b0, lane_q, 2'(k)} < beat_bytes) ? wr_data[8*k +: 8] : 8'h00;
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        pld_bytes_d = pld_bytes_q;
        lane_d      = lane_q;
        beat_d      = beat_q;
        done_d      = done_q;
        cfg_err_d   = cfg_err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) done_d = 1'b1;
                if (start_pulse) begin
                    if (!len_ok) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_err_d   = 1'b0;
                        done_d      = 1'b0;
                        beat_d      = 128'd0;
                        lane_d      = 2'd0;
                        pld_bytes_d = pld_bytes;
                        if (aad_bytes != 61'd0) begin
                            state_d = S_AAD_FILL;
                            rem_d   = aad_bytes;
                        end else if (pld_bytes != 61'd0) begin
                            state_d = S_PLD_FILL;
                            rem_d   = pld_bytes;
                        end else begin
                            state_d = S_DONE;
                            rem_d   = 61'd0;
                        end
                    end
                end
            end
            S_AAD_FILL, S_PLD_FILL: begin
                if (wr_valid) begin
                    beat_d[32*lane_q +: 32] = wr_masked;
                    if (last_word) begin
                        lane_d  = 2'd0;
                        state_d = (state_q == S_AAD_FILL) ? S_AAD_SEND : S_PLD_SEND;
                    end else begin
                        lane_d = lane_q + 2'd1;
                    end
                end
            end
            S_AAD_SEND, S_PLD_SEND: begin
                if ((state_q == S_AAD_SEND) ? aad_ready : din_ready) begin
                    beat_d = 128'd0;
                    lane_d = 2'd0;
                    if (rem_after != 61'd0) begin
                        rem_d   = rem_after;
                        state_d = (state_q == S_AAD_SEND) ? S_AAD_FILL : S_PLD_FILL;
                    end else if ((state_q == S_AAD_SEND) && (pld_bytes_q != 61'd0)) begin
                        rem_d   = pld_bytes_q;
                        state_d = S_PLD_FILL;
                    end else begin
                        rem_d   = 61'd0;
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            rem_q       <= 61'd0;
            pld_bytes_q <= 61'd0;
            lane_q      <= 2'd0;
            beat_q      <= 128'd0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            rem_q       <= rem_d;
            pld_bytes_q <= pld_bytes_d;
            lane_q      <= lane_d;
            beat_q      <= beat_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign wr_ready  = (state_q == S_AAD_FILL) || (state_q == S_PLD_FILL);
    assign aad_valid = (state_q == S_AAD_SEND);
    assign aad_data  = aad_valid ? beat_q : 128'd0;
    assign aad_keep  = aad_valid ? beat_keep : 16'd0;
    assign aad_last  = aad_valid && beat_last;
    assign din_valid = (state_q == S_PLD_SEND);
    assign din_data  = din_valid ? beat_q : 128'd0;
    assign din_keep  = din_valid ? beat_keep : 16'd0;
    assign din_last  = din_valid && beat_last;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_aes_gcm_stream_src.sv
// Directed bench for aes_gcm_stream_src: host-word pushes, beat checks on
// both channels, backpressure, rejected starts, empty message and reset.
module tb_aes_gcm_stream_src;

    logic          clk, rst_n, start;
    logic [63:0]   len_aad_bits, len_pld_bits;
    logic          wr_valid, wr_ready;
    logic [31:0]   wr_data;
    logic          aad_valid, aad_ready, aad_last;
    logic [127:0]  aad_data;
    logic [15:0]   aad_keep;
    logic          din_valid, din_ready, din_last;
    logic [127:0]  din_data;
    logic [15:0]   din_keep;
    logic          busy, done, cfg_err;

    int checks = 0;
    int errors = 0;
    int din_vcycles = 0;
    int both_cycles = 0;
    int din_base;

    aes_gcm_stream_src dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .len_aad_bits(len_aad_bits), .len_pld_bits(len_pld_bits),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .aad_valid(aad_valid), .aad_ready(aad_ready), .aad_data(aad_data),
        .aad_keep(aad_keep), .aad_last(aad_last),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .din_keep(din_keep), .din_last(din_last),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (din_valid) din_vcycles++;
        if (din_valid && aad_valid) both_cycles++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [63:0] la, input logic [63:0] lp);
        start = 1'b0;
        @(posedge clk); #1;
        len_aad_bits = la;
        len_pld_bits = lp;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        wr_data  = w;
        wr_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        chk("push_accept", 128'(ok), 128'd1);
    endtask

    task automatic get_beat(input bit is_aad, input logic [127:0] ed, input logic [15:0] ek,
                            input logic el, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (is_aad ? aad_valid : din_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, "_found"}, 128'(found), 128'd1);
        if (found) begin
            if (is_aad) begin
                chk({tag, "_data"}, aad_data, ed);
                chk({tag, "_keep_last"}, 128'({aad_keep, aad_last}), 128'({ek, el}));
                chk({tag, "_other_idle"}, {din_data[126:0], din_valid}, 128'd0);
                chk({tag, "_other_ctl"}, 128'({din_data[127], din_keep, din_last}), 128'd0);
            end else begin
                chk({tag, "_data"}, din_data, ed);
                chk({tag, "_keep_last"}, 128'({din_keep, din_last}), 128'({ek, el}));
                chk({tag, "_other_idle"}, {aad_data[126:0], aad_valid}, 128'd0);
                chk({tag, "_other_ctl"}, 128'({aad_data[127], aad_keep, aad_last}), 128'd0);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; wr_valid = 1'b0; wr_data = 32'd0;
        len_aad_bits = 64'd0; len_pld_bits = 64'd0;
        aad_ready = 1'b1; din_ready = 1'b1;

        #12;
        chk("reset_ctl", 128'({wr_ready, aad_valid, aad_last, din_valid, din_last, busy, done, cfg_err}), 128'd0);
        chk("reset_aad_data", aad_data, 128'd0);
        chk("reset_din_data", din_data, 128'd0);
        chk("reset_keeps", 128'({aad_keep, din_keep}), 128'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Rejected start: AAD length not a whole number of bytes
        pulse_start(64'd12, 64'd0);
        chk("rej_cfg_err", 128'(cfg_err), 128'd1);
        chk("rej_idle", 128'({busy, done, wr_ready}), 128'd0);
        @(posedge clk); #1;
        chk("rej_sticky", 128'({cfg_err, busy}), 128'b10);

        // AAD 20 bytes, no payload
        din_base = din_vcycles;
        pulse_start(64'd160, 64'd0);
        chk("t1_cfg_err_clr", 128'({cfg_err, busy, wr_ready}), 128'b011);
        push(32'h03020100);
        push(32'h07060504);
        push(32'h0b0a0908);
        push(32'h0f0e0d0c);
        chk("t1_latency", 128'({aad_valid, wr_ready}), 128'b10);
        get_beat(1'b1, 128'h0f0e0d0c_0b0a0908_07060504_03020100, 16'hFFFF, 1'b0, "t1_b1");
        push(32'h13121110);
        get_beat(1'b1, 128'h00000000_00000000_00000000_13121110, 16'h000F, 1'b1, "t1_b2");
        chk("t1_done", 128'({done, busy}), 128'b10);
        chk("t1_no_din", 128'(din_vcycles - din_base), 128'd0);

        // Payload 13 bytes: surplus bytes of the final word are discarded
        pulse_start(64'd0, 64'd104);
        chk("t2_done_clr", 128'({done, busy}), 128'b01);
        push(32'h03020100);
        push(32'h07060504);
        push(32'h0b0a0908);
        push(32'hDDCCBB0C);
        get_beat(1'b0, 128'h0000000c_0b0a0908_07060504_03020100, 16'h1FFF, 1'b1, "t2_b1");
        chk("t2_done", 128'({done, busy}), 128'b10);

        // AAD 8 bytes then payload 32 bytes
        pulse_start(64'd64, 64'd256);
        push(32'hA3A2A1A0);
        push(32'hA7A6A5A4);
        get_beat(1'b1, 128'h00000000_00000000_A7A6A5A4_A3A2A1A0, 16'h00FF, 1'b1, "t3_aad");
        chk("t3_pld_fill", 128'({wr_ready, busy, done}), 128'b110);
        push(32'hC0C0C000);
        push(32'hC0C0C001);
        push(32'hC0C0C002);
        push(32'hC0C0C003);
        get_beat(1'b0, 128'hC0C0C003_C0C0C002_C0C0C001_C0C0C000, 16'hFFFF, 1'b0, "t3_d1");
        push(32'hC0C0C004);
        push(32'hC0C0C005);
        push(32'hC0C0C006);
        push(32'hC0C0C007);
        get_beat(1'b0, 128'hC0C0C007_C0C0C006_C0C0C005_C0C0C004, 16'hFFFF, 1'b1, "t3_d2");
        chk("t3_done", 128'({done, busy}), 128'b10);

        // Backpressure on the payload channel
        din_ready = 1'b0;
        pulse_start(64'd0, 64'd128);
        push(32'h33221100);
        push(32'h77665544);
        push(32'hBBAA9988);
        push(32'hFFEEDDCC);
        wr_valid = 1'b1;
        wr_data  = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_data", din_data, 128'hFFEEDDCC_BBAA9988_77665544_33221100);
            chk("t4_hold_ctl", 128'({din_valid, din_keep, din_last, wr_ready}), 128'({1'b1, 16'hFFFF, 1'b1, 1'b0}));
        end
        @(negedge clk);
        din_ready = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        chk("t4_sent", 128'({din_valid, done, busy}), 128'b010);

        // Reset in the middle of an AAD fill
        pulse_start(64'd64, 64'd0);
        push(32'h11111111);
        @(negedge clk);
        wr_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", 128'({wr_ready, aad_valid, aad_last, din_valid, din_last, busy, done, cfg_err}), 128'd0);
        chk("rst_mid_data", aad_data | din_data, 128'd0);
        @(negedge clk);
        wr_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty message: done one cycle after the accepting edge, no beats
        pulse_start(64'd0, 64'd0);
        chk("t6_entry", 128'({done, busy, aad_valid, din_valid, wr_ready}), 128'd0);
        @(posedge clk); #1;
        chk("t6_done", 128'({done, busy, aad_valid, din_valid}), 128'b1000);

        // Normal operation after reset
        pulse_start(64'd32, 64'd0);
        chk("t6b_start", 128'({done, busy}), 128'b01);
        push(32'hEEDDCCBB);
        get_beat(1'b1, 128'h00000000_00000000_00000000_EEDDCCBB, 16'h000F, 1'b1, "t6b_aad");
        chk("t6b_done", 128'({done, busy}), 128'b10);

        chk("channel_exclusive", 128'(both_cycles), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_gcm_stream_src.md
Name: aes_gcm_stream_src

Overview:
- Transmit-side stream source that feeds the AES-GCM core's AAD and payload input channels.
- Accepts 32-bit host words and packs them into 128-bit beats with byte-keep masks and last flags.
- Sequences the AAD section first, then the payload section, sized by the bit lengths latched at start.
- Drives the same aad_*/din_* valid/ready/keep/last interface that the GCM controller and datapath consume.

Parameters:
- None. Widths are fixed: 32-bit host word, 128-bit beat, 64-bit lengths.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; a rising edge starts a message
- len_aad_bits  in  64  AAD length in bits, sampled on the start edge
- len_pld_bits  in  64  payload length in bits, sampled on the start edge
- wr_valid  in  1  host word valid
- wr_ready  out  1  host word accepted when wr_valid && wr_ready
- wr_data  in  32  host word; byte k of the word is wr_data[8k+7:8k]
- aad_valid  out  1  AAD beat valid
- aad_ready  in  1  AAD beat accept
- aad_data  out  128  AAD beat; section byte j of the beat is bits [8j+7:8j]
- aad_keep  out  16  one bit per valid byte
- aad_last  out  1  final AAD beat
- din_valid / din_ready / din_data[127:0] / din_keep[15:0] / din_last  same as aad_*, for the payload channel
- busy  out  1  high while a message is in progress
- done  out  1  level; high once all beats are sent, cleared on the next accepted start
- cfg_err  out  1  sticky; set when a start is rejected, cleared on the next accepted start

Behaviour:
- Reset: all outputs 0, state IDLE, beat register zeroed.
- Start edge: start_pulse = start && !start_d.
  - Accepted only in IDLE or DONE.
  - Rejected (cfg_err<=1, state unchanged) if len_aad_bits[2:0]!=0 or len_pld_bits[2:0]!=0.
  - Ignored while busy.
- Byte counts: aad_bytes = len_aad_bits>>3, pld_bytes = len_pld_bits>>3, each held in a 61-bit remaining-byte counter.
- States: IDLE, AAD_FILL, AAD_SEND, PLD_FILL, PLD_SEND, DONE.
- On an accepted start:
  - Go to AAD_FILL if aad_bytes!=0.
  - Else go to PLD_FILL if pld_bytes!=0.
  - Else go to DONE.
  - done<=0 on entry; if both lengths are 0, done is set the next cycle and no beat is ever issued.
- FILL states:
  - wr_ready=1 only in FILL states.
  - beat_bytes = min(16, remaining). beat_words = ceil(beat_bytes/4).
  - Accepted words are placed in word lane 0..3 in order.
  - After beat_words words are accepted, move to SEND on the next edge.
  - Bytes at or above beat_bytes are forced to 0 in data; surplus bytes in the final host word are discarded.
- SEND states:
  - valid=1. keep = (1<<beat_bytes)-1. last = (remaining==beat_bytes).
  - data, keep and last stay stable until ready.
  - wr_ready=0.
  - On handshake: remaining -= beat_bytes, word lane resets to 0. Then:
    - If remaining is still nonzero, return to the same section's FILL state.
    - Else, if the AAD section just finished and pld_bytes!=0, go to PLD_FILL.
    - Otherwise go to DONE.
- Alignment: each section starts on a fresh host word and a fresh beat; AAD bytes never share a word with payload bytes.
- Latency: the beat is valid in the cycle after its final word is accepted. Sustained rate is one beat per (beat_words+1) cycles with ready held high.
- Channel exclusivity: aad_valid and din_valid are never high together; the inactive channel's data/keep/last outputs are 0.
- busy=1 in every state except IDLE and DONE.
- Reset mid-operation: immediate return to IDLE, all valids drop; partial beats are lost.

Test Plan:
1. AAD 160 bits, payload 0, words 0x03020100, 0x07060504, … → aad beat 1 data bytes 0x00..0x0F, keep=FFFF, last=0; beat 2 bytes 0x10..0x13 with upper bytes zero, keep=000F, last=1; din_valid never high; done=1, busy=0.
2. AAD 0, payload 104 bits (13 bytes), 4 words where the last is 0xDDCCBB0C → one din beat, keep=1FFF, last=1, data[103:96]=0x0C, data[127:104]=0.
3. AAD 64 bits then payload 256 bits → one aad beat (keep=00FF, last=1), then two din beats, each keep=FFFF, second last=1; the third host word goes to the payload channel.
4. Backpressure: din_ready held low for 5 cycles during PLD_SEND → din_data/keep/last unchanged, wr_ready=0 throughout; beat sent on the first ready cycle.
5. len_aad_bits=12 → cfg_err=1, state stays IDLE, busy=0; a following start with valid lengths clears cfg_err.
6. Both lengths 0 → done=1 one cycle after the start edge, no valids; rst_n asserted mid-AAD_FILL → all outputs 0 immediately, and a new start works normally.
